// File: rtl/sll_multicycle_if.sv
// Operand/result handshake bundle for the iterative left shifter.
// slave = shifter side, master = ALU sequencer side.
interface sll_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               overflow;
  logic               busy;

  modport slave (
    input  flush, in_valid, data_operandA,
    input  ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result,
    output overflow, busy
  );

  modport master (
    output flush, in_valid, data_operandA,
    output ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result,
    input  overflow, busy
  );
endinterface

// File: rtl/sll_multicycle.sv
// Iterative logical-left shifter, up to STEP positions per cycle,
// with sticky overflow on any 1 bit shifted past the MSB.
module sll_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  sll_multicycle_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH+STEP-1:0] wide;

  // Upper STEP bits of wide catch whatever falls off the top.
  always_comb begin
    k = (int'(rem_q) < STEP) ? rem_q
                             : SHAMT_W'(STEP);
    wide = {{STEP{1'b0}}, acc_q} << k;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d = bus.data_operandA;
          rem_d = bus.ctrl_shiftamt;
          ovf_d = 1'b0;
          if (bus.ctrl_shiftamt == '0) begin
            state_d = DONE;
            res_d   = bus.data_operandA;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = wide[WIDTH-1:0];
        rem_d = rem_q - k;
        ovf_d = ovf_q | (|wide[WIDTH+STEP-1:WIDTH]);
        if (rem_d == '0) begin
          state_d = DONE;
          res_d   = wide[WIDTH-1:0];
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      res_d   = res_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.data_result = res_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_sll_multicycle.sv
// Directed bench for sll_multicycle: vector table plus
// backpressure, flush and reset sequences.
module tb_sll_multicycle;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sll_multicycle_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  sll_multicycle #(
    .WIDTH(32), .SHAMT_W(5), .STEP(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [31:0] a,
                        input logic [4:0] sh);
    bus.in_valid = 1'b1;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = sh;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.ctrl_shiftamt = 5'd7;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic watch_quiet(input string nm);
    logic seen;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (bus.out_valid) seen = 1'b1;
    end
    chk(nm, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h12345678, 5'd0,  32'h12345678, 1'b0, 1};
    vecs[1]  = '{32'h00000001, 5'd31, 32'h80000000, 1'b0, 9};
    vecs[2]  = '{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b1, 2};
    vecs[3]  = '{32'h0000000F, 5'd5,  32'h000001E0, 1'b0, 3};
    vecs[4]  = '{32'h00000001, 5'd1,  32'h00000002, 1'b0, 2};
    vecs[5]  = '{32'h00000003, 5'd2,  32'h0000000C, 1'b0, 2};
    vecs[6]  = '{32'h00000005, 5'd3,  32'h00000028, 1'b0, 2};
    vecs[7]  = '{32'h00FF0000, 5'd8,  32'hFF000000, 1'b0, 3};
    vecs[8]  = '{32'h80000000, 5'd1,  32'h00000000, 1'b1, 2};
    vecs[9]  = '{32'h0F000000, 5'd5,  32'hE0000000, 1'b1, 3};
    vecs[10] = '{32'h00000003, 5'd30, 32'hC0000000, 1'b0, 9};
    vecs[11] = '{32'h00000007, 5'd30, 32'hC0000000, 1'b1, 9};
    vecs[12] = '{32'h00000000, 5'd17, 32'h00000000, 1'b0, 6};

    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_operandA = '0;
    bus.ctrl_shiftamt = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clock);
    chk("rst result", bus.data_result, 32'd0);
    chk("rst ovf", {31'b0, bus.overflow}, 32'd0);
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst busy", {31'b0, bus.busy}, 32'd0);
    chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d in_ready", i),
          {31'b0, bus.in_ready}, 32'd1);
      accept(vecs[i].a, vecs[i].sh);
      wait_out(lat);
      chk($sformatf("v%0d latency", i),
          32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d result", i),
          bus.data_result, vecs[i].res);
      chk($sformatf("v%0d ovf", i),
          {31'b0, bus.overflow}, {31'b0, vecs[i].ovf});
      @(negedge clock);
    end

    // Backpressure with a second operand offered while busy
    bus.out_ready = 1'b0;
    accept(32'h0000000F, 5'd5);
    wait_out(lat);
    chk("bp latency", 32'(lat), 32'd3);
    bus.in_valid = 1'b1;
    bus.data_operandA = 32'h00000001;
    bus.ctrl_shiftamt = 5'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("bp hold%0d result", c),
          bus.data_result, 32'h000001E0);
      chk($sformatf("bp hold%0d out_valid", c),
          {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("bp hold%0d in_ready", c),
          {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp release out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("bp release in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("bp second latency", 32'(lat), 32'd2);
    chk("bp second result", bus.data_result, 32'h00000002);
    @(negedge clock);

    // Flush during SHIFT
    accept(32'hFFFFFFFF, 5'd20);
    chk("flush pre busy", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush busy", {31'b0, bus.busy}, 32'd0);
    chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush result kept", bus.data_result, 32'h00000002);
    watch_quiet("flush no out_valid");

    // Flush beats in_valid in IDLE
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_operandA = 32'h5;
    bus.ctrl_shiftamt = 5'd0;
    @(negedge clock);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush+valid busy", {31'b0, bus.busy}, 32'd0);
    chk("flush+valid out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Async reset during SHIFT
    accept(32'hFFFFFFFF, 5'd4);
    wait_out(lat);
    chk("pre-rst ovf", {31'b0, bus.overflow}, 32'd1);
    @(negedge clock);
    accept(32'hFFFFFFFF, 5'd20);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst result", bus.data_result, 32'd0);
    chk("arst ovf", {31'b0, bus.overflow}, 32'd0);
    chk("arst in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("arst busy", {31'b0, bus.busy}, 32'd0);
    chk("arst out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    watch_quiet("arst no out_valid");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sll_multicycle.md
Name: sll_multicycle

Overview:
- Iterative logical-left shifter for the processor ALU; the left-direction counterpart of the combinational arithmetic-right barrel shifter.
- Shifts by at most STEP positions per clock, trading latency for area.
- Uses valid/ready handshakes on both input and output so the multi-cycle ALU stall logic can sequence it.
- Reports a sticky overflow flag: any 1 bit shifted out past bit WIDTH-1.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; shift range is 0 to 2^SHAMT_W-1.
- STEP, 4, maximum positions shifted per cycle; power of two, 1 to 16.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; highest priority after reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts an operand this cycle.
- data_operandA  in  WIDTH  value to shift.
- ctrl_shiftamt  in  SHAMT_W  shift distance.
- out_valid  out  1  data_result and overflow are valid.
- out_ready  in  1  consumer takes the result.
- data_result  out  WIDTH  operandA << shiftamt, zero-filled.
- overflow  out  1  set if any shifted-out bit was 1.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state = IDLE; data_result = 0; overflow = 0; out_valid = 0; busy = 0; in_ready = 1.
  - Reset asserted mid-operation discards the operation; no result is produced.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE:
  - On in_valid && in_ready (cycle t), register acc = data_operandA, rem = ctrl_shiftamt, overflow = 0.
  - Go to DONE if rem==0, else go to SHIFT.
- SHIFT, each cycle:
  - k = min(rem, STEP).
  - overflow |= OR of acc[WIDTH-1 : WIDTH-k].
  - acc = acc << k; rem = rem - k.
  - Go to DONE when the new rem==0.
- DONE:
  - data_result = acc, held stable with overflow while out_ready is low (no change under backpressure).
  - On out_ready, go to IDLE.
  - No same-cycle accept: in_ready is low in DONE, so a new operand is taken at the earliest in the cycle after the handshake.
- Latency:
  - out_valid rises at t+1 when shamt==0.
  - Otherwise out_valid rises at t+1+ceil(shamt/STEP).
  - With STEP=4: shamt 31 gives t+9; shamt 4 gives t+2; shamt 5 gives t+3.
- in_valid while busy is ignored. Operand inputs are sampled only at accept; later changes have no effect.
- flush, synchronous:
  - Next state is IDLE and out_valid drops; data_result keeps its last value.
  - flush and in_valid in the same IDLE cycle: flush wins and no accept occurs.
- Arithmetic:
  - Zero fill from the LSB.
  - Shift amounts >= WIDTH are possible only if SHAMT_W > log2(WIDTH); they yield result 0, and overflow = (operand != 0).
- data_result is registered, with no combinational path from inputs to data_result.

Test Plan:
- Zero shift: A=0x12345678, shamt=0 accepted at t -> out_valid at t+1, result 0x12345678, overflow 0.
- Full-range shift: A=0x00000001, shamt=31 -> out_valid at t+9, result 0x80000000, overflow 0.
- Single step with overflow: A=0xFFFFFFFF, shamt=4 -> out_valid at t+2, result 0xFFFFFFF0, overflow 1.
- Backpressure and busy: A=0x0000000F, shamt=5 -> out_valid at t+3, result 0x000001E0.
  - Hold out_ready=0 for 4 cycles; result stays stable.
  - Drive in_valid with a second operand during busy; it is ignored.
  - Pulse out_ready; the next cycle in_ready=1, and the second operand is accepted only then.
- Abort: reset_n low during SHIFT (shamt=20) -> outputs immediately 0, in_ready=1, no out_valid afterward.
  - Repeat with flush instead of reset -> IDLE next cycle, no out_valid.
- Back-to-back sequence: shamt 1, 2, 3, 8 with out_ready tied high -> results and latencies match the formula (t+2, t+2, t+2, t+3 relative to each accept).
